cont_sinc_cresc: RTL

//  Synchronous up counter, modulo MODULO, with parallel load, count enable and terminal-count/carry outputs.
//  It is the ascending, single-clock counterpart of the ripple down counter in this library.
//  All state bits switch on the same clk edge, so there is no ripple settling.

---
 rtl/cont_sinc_cresc.sv | 93 +++++++++
 1 files changed

// File: rtl/cont_sinc_cresc.sv
// cont_sinc_cresc: synchronous modulo-MODULO up counter with parallel load,
// count enable, terminal count and sticky wrap flag. Cascadable: tc of one
// stage drives en of the next, and both count on the same clk edge.
//
// Ports
//   clk       clock, all state changes on posedge
//   rst       synchronous reset, active-high
//   en        count enable
//   load      parallel load strobe (has priority over en)
//   d         parallel load value
//   clr_wrap  clears the sticky wrap flag (a rollover on the same edge wins)
//   q         registered count value
//   qnot      registered bitwise complement of q
//   tc        combinational terminal count, (q == MODULO-1) & en
//   wrap      sticky flag, set on every MODULO-1 -> 0 rollover
//   load_err  registered, high for the cycle after a rejected load (d >= MODULO)
module cont_sinc_cresc #(
   parameter int unsigned WIDTH  = 6,
   parameter int unsigned MODULO = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             clr_wrap,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qnot,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULO - 1);

   logic             at_term;
   logic             d_ok;
   logic             rollover;
   logic             carry;
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] q_nx;
   logic             wrap_nx;
   logic             err_nx;

   assign at_term  = (q == TERM);
   // Compare in 32 bits so MODULO = 2**WIDTH is representable
   assign d_ok     = (32'(d) < MODULO);
   assign rollover = ~load & en & at_term;
   assign tc       = at_term & en;

   // Toggle-stage next state: each bit flips when its T input is high
   always_comb begin
      t       = '0;
      carry   = en;
      q_nx    = q;
      wrap_nx = wrap;
      err_nx  = 1'b0;

      // Carry chain: T_i = en & (&q[i-1:0])
      for (int unsigned i = 0; i < WIDTH; i++) begin
         t[i]  = carry;
         carry = carry & q[i];
      end

      if (load) begin
         // Load expressed as toggling every bit that differs from the target
         t      = q ^ (d_ok ? d : '0);
         err_nx = ~d_ok;
      end else if (rollover) begin
         // Terminal state overrides the chain: toggle every set bit to reach 0
         t = q;
      end

      q_nx    = q ^ t;
      wrap_nx = rollover | (wrap & ~clr_wrap);
   end

   // State registers; reset has priority over every other input
   always_ff @(posedge clk) begin
      if (rst) begin
         q        <= '0;
         qnot     <= '1;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         q        <= q_nx;
         qnot     <= ~q_nx;
         wrap     <= wrap_nx;
         load_err <= err_nx;
      end
   end

endmodule
